ddr_test_sequencer: RTL and testbench

Self-contained traffic sequencer driving one AXI4 master port into the DDRMC through the NoC. A push-button start runs one pass: write a deterministic pattern over a fixed address window, read it back, and compare. Results go to the top-level `out` status bus. Transactions are single-beat and strictly serialized, with one outstanding transaction at a time.

---
 rtl/ddr_test_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ddr_test_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_test_sequencer.sv
// Single-beat AXI4 write/read-back/compare traffic sequencer for DDRMC bring-up.
// One pass per start push: write a seeded pattern over a window, read it back, report on `out`.
module ddr_test_sequencer #(
    parameter int          ADDR_W    = 64,
    parameter int          DATA_W    = 128,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          NUM_WORDS = 256,
    parameter logic [31:0] SEED      = 32'hA5A5_0000,
    parameter int          TIMEOUT   = 4096,
    parameter int          WIDTH     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              busy,
    output logic [WIDTH-1:0]  out
);
    localparam int BYTES = DATA_W / 8;
    localparam int REPS  = DATA_W / 32;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int ERR_W = WIDTH - 3;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD, S_RD_R, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [ERR_W-1:0]   err_cnt;
    logic [WD_W-1:0]    wd;
    logic               done_q, to_q, to_fire;
    logic               sync1, sync2, sync3, start_pulse;
    logic               start_go, entering, last;
    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs, err_inc;
    logic [31:0]        word;
    logic [DATA_W-1:0]  pattern;
    logic               unused_rlast;

    assign unused_rlast = m_axi_rlast;

    // Address and data are pure functions of idx, so they stay stable while a valid waits.
    assign word          = SEED + 32'(idx);
    assign pattern       = {REPS{word}};
    assign m_axi_awaddr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(BYTES);
    assign m_axi_araddr  = m_axi_awaddr;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_awsize  = 3'($clog2(BYTES));
    assign m_axi_arsize  = 3'($clog2(BYTES));
    assign m_axi_awburst = 2'b01;
    assign m_axi_arburst = 2'b01;
    assign m_axi_wdata   = pattern;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_bready  = (state == S_WR_B);
    assign m_axi_rready  = (state == S_RD_R);

    assign busy     = !(state == S_IDLE || state == S_DONE);
    assign out      = {done_q, done_q && (err_cnt == '0) && !to_q, to_q, err_cnt};
    assign aw_hs    = m_axi_awvalid && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign b_hs     = m_axi_bvalid && m_axi_bready;
    assign ar_hs    = m_axi_arvalid && m_axi_arready;
    assign r_hs     = m_axi_rvalid && m_axi_rready;
    assign last     = (idx == IDX_W'(NUM_WORDS - 1));
    assign start_go = start_pulse && !busy;
    assign entering = (state_nxt != state);
    assign err_inc  = (b_hs && m_axi_bresp != 2'b00) ||
                      (r_hs && (m_axi_rresp != 2'b00 || m_axi_rdata != pattern));

    always_comb begin
        state_nxt = state;
        to_fire   = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start_pulse) state_nxt = S_WR;
            S_WR:   if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready))
                        state_nxt = S_WR_B;
            S_WR_B: if (b_hs) state_nxt = last ? S_RD : S_WR;
            S_RD:   if (ar_hs) state_nxt = S_RD_R;
            S_RD_R: if (r_hs) state_nxt = last ? S_DONE : S_RD;
            default: state_nxt = S_IDLE;
        endcase
        // A completing handshake wins over the watchdog on the same cycle.
        if (busy && state_nxt == state && wd == WD_W'(TIMEOUT - 1)) begin
            state_nxt = S_DONE;
            to_fire   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            sync1       <= start;
            sync2       <= sync1;
            sync3       <= sync2;
            start_pulse <= sync2 && !sync3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            idx           <= '0;
            err_cnt       <= '0;
            wd            <= '0;
            done_q        <= 1'b0;
            to_q          <= 1'b0;
        end else begin
            wd <= entering ? '0 : (busy ? wd + 1'b1 : wd);

            if (to_fire)                             m_axi_awvalid <= 1'b0;
            else if (entering && state_nxt == S_WR)  m_axi_awvalid <= 1'b1;
            else if (aw_hs)                          m_axi_awvalid <= 1'b0;

            if (to_fire)                             m_axi_wvalid <= 1'b0;
            else if (entering && state_nxt == S_WR)  m_axi_wvalid <= 1'b1;
            else if (w_hs)                           m_axi_wvalid <= 1'b0;

            if (to_fire)                             m_axi_arvalid <= 1'b0;
            else if (entering && state_nxt == S_RD)  m_axi_arvalid <= 1'b1;
            else if (ar_hs)                          m_axi_arvalid <= 1'b0;

            if (start_go) begin
                idx     <= '0;
                err_cnt <= '0;
                done_q  <= 1'b0;
                to_q    <= 1'b0;
            end else begin
                if (b_hs)          idx <= last ? '0 : idx + 1'b1;
                if (r_hs && !last) idx <= idx + 1'b1;
                if (err_inc && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (to_fire) to_q <= 1'b1;
                if (entering && state_nxt == S_DONE) done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Randomized AXI slave plus transaction-level reference model for ddr_test_sequencer.
module tb_ddr_test_sequencer;
    localparam int          NW   = 4;
    localparam int          TO   = 16;
    localparam logic [63:0] BASE = 64'h0;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [63:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
    logic [127:0] wdata, rdata = '0;
    logic [15:0]  wstrb;
    logic [1:0]   bresp = 2'b00, rresp = 2'b00;
    logic         bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic         rlast = 1'b0, rvalid = 1'b0, rready, busy;
    logic [7:0]   out;

    ddr_test_sequencer #(.ADDR_W(64), .DATA_W(128), .BASE_ADDR(BASE), .NUM_WORDS(NW),
                         .SEED(SEED), .TIMEOUT(TO), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy), .out(out));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [31:0] w;
        w = SEED + 32'(i);
        return {4{w}};
    endfunction

    // slave configuration
    int         maxd = 0;
    bit         aw_stuck = 0, model_en = 1;
    logic [3:0] bslv = '0, rslv = '0, rcor = '0;
    function automatic int rnd();
        return int'($urandom_range(32'(maxd), 0));
    endfunction

    // slave state
    int           aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit           aw_got, w_got, ar_got;
    logic [63:0]  aw_a, ar_a;
    logic [127:0] w_d;
    logic [127:0] mem [logic [63:0]];
    logic [63:0]  aw_log [$];
    logic [127:0] w_log [$];

    // reference model: pass progress counted in transactions
    int       m_aw, m_w, m_b, m_ar, m_r, m_err;
    bit       m_busy, m_done;
    bit [4:0] sh;
    bit       p_awv, p_wv, p_arv, p_hs_aw, p_hs_w, p_hs_ar;
    logic [63:0]  p_awa, p_ara;
    logic [127:0] p_wd;

    always @(negedge clk) begin
        bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
            rvalid = 0; rresp = 0; rdata = '0; rlast = 0;
            aw_cnt = -1; w_cnt = -1; b_cnt = -1; ar_cnt = -1; r_cnt = -1;
            aw_got = 0; w_got = 0; ar_got = 0;
            m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0; m_err = 0;
            m_busy = 0; m_done = 0; sh = '0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_hs_aw = 0; p_hs_w = 0; p_hs_ar = 0;
        end else begin
            if (model_en) begin
                chk("busy", busy, m_busy);
                chk("out", out, {m_done, m_done && m_err == 0, 1'b0, 5'(m_err)});
                if (p_awv && !p_hs_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awa});
                if (p_wv && !p_hs_w)   chk("w_hold", {wvalid, wdata}, {1'b1, p_wd});
                if (p_arv && !p_hs_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, p_ara});
            end
            // response channels act on handshakes already committed
            bvalid = 0; bresp = 0;
            if (aw_got && w_got) begin
                if (b_cnt < 0) b_cnt = rnd();
                if (b_cnt == 0) begin
                    bvalid = 1;
                    bresp = (m_b < NW && bslv[m_b]) ? 2'b10 : 2'b00;
                end else b_cnt--;
            end
            hs_b = bvalid && bready;
            if (hs_b) begin mem[aw_a] = w_d; aw_got = 0; w_got = 0; b_cnt = -1; end

            rvalid = 0; rresp = 0; rlast = 0;
            if (ar_got) begin
                if (r_cnt < 0) r_cnt = rnd();
                if (r_cnt == 0) begin
                    rvalid = 1; rlast = 1;
                    rdata = mem.exists(ar_a) ? mem[ar_a] : '0;
                    if (m_r < NW && rcor[m_r]) rdata = rdata ^ 128'h1;
                    rresp = (m_r < NW && rslv[m_r]) ? 2'b10 : 2'b00;
                end else r_cnt--;
            end
            hs_r = rvalid && rready;
            if (hs_r) begin ar_got = 0; r_cnt = -1; end

            awready = 0;
            if (awvalid && !aw_stuck) begin
                if (aw_cnt < 0) aw_cnt = rnd();
                if (aw_cnt == 0) awready = 1; else aw_cnt--;
            end
            hs_aw = awvalid && awready;
            if (hs_aw) begin aw_cnt = -1; aw_got = 1; aw_a = awaddr; end

            wready = 0;
            if (wvalid) begin
                if (w_cnt < 0) w_cnt = rnd();
                if (w_cnt == 0) wready = 1; else w_cnt--;
            end
            hs_w = wvalid && wready;
            if (hs_w) begin w_cnt = -1; w_got = 1; w_d = wdata; end

            arready = 0;
            if (arvalid) begin
                if (ar_cnt < 0) ar_cnt = rnd();
                if (ar_cnt == 0) arready = 1; else ar_cnt--;
            end
            hs_ar = arvalid && arready;
            if (hs_ar) begin ar_cnt = -1; ar_got = 1; ar_a = araddr; end

            // model: state after the coming posedge
            if (hs_aw) begin
                chk("aw_serial", m_aw, m_b);
                chk("awaddr", awaddr, BASE + 64'(m_aw) * 64'd16);
                aw_log.push_back(awaddr); m_aw++;
            end
            if (hs_w) begin
                chk("wbeat", {wlast, wstrb, wdata}, {1'b1, 16'hFFFF, pat(m_w)});
                w_log.push_back(wdata); m_w++;
            end
            if (hs_b) begin
                if (bresp != 2'b00 && m_err < 31) m_err++;
                m_b++;
            end
            if (hs_ar) begin
                chk("ar_after_wr", m_b, NW);
                chk("ar_serial", m_ar, m_r);
                chk("araddr", araddr, BASE + 64'(m_ar) * 64'd16);
                m_ar++;
            end
            if (hs_r) begin
                if ((rresp != 2'b00 || rdata != pat(m_r)) && m_err < 31) m_err++;
                m_r++;
                if (m_r == NW) begin m_busy = 0; m_done = 1; end
            end
            // a start level sampled at edge k starts the pass at edge k+3
            sh = {sh[3:0], start};
            if (sh[3] && !sh[4] && !m_busy) begin
                m_busy = 1; m_done = 0; m_err = 0;
                m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
            end
            p_awv = awvalid; p_awa = awaddr; p_hs_aw = hs_aw;
            p_wv = wvalid; p_wd = wdata; p_hs_w = hs_w;
            p_arv = arvalid; p_ara = araddr; p_hs_ar = hs_ar;
        end
    end

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic run_pass(input string nm, input logic [7:0] exp_out,
                            input bit lat_chk, input bit mid_start);
        int n;
        aw_log.delete(); w_log.delete();
        @(posedge clk); #1 start = 1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); #1;
            if (lat_chk && j == 3) chk({nm, "_lat_lo"}, awvalid, 1'b0);
            if (lat_chk && j == 4) chk({nm, "_lat_hi"}, {awvalid, wvalid}, 2'b11);
        end
        @(posedge clk); #1 start = 0;
        if (mid_start) begin
            n = 0;
            while (m_aw < 2 && n < 500) begin @(negedge clk); #1; n++; end
            chk({nm, "_mid_reach"}, m_aw >= 2, 1'b1);
            @(posedge clk); #1 start = 1;
            repeat (3) @(posedge clk);
            #1 start = 0;
        end
        n = 0;
        while (!m_done && n < 3000) begin @(negedge clk); #1; n++; end
        chk({nm, "_finish"}, m_done, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk({nm, "_out"}, out, exp_out);
        chk({nm, "_idle"}, busy, 1'b0);
        chk({nm, "_nwr"}, aw_log.size(), NW);
    endtask

    initial begin
        int n;
        do_reset();
        @(negedge clk); #1;
        chk("rst_out", out, 8'h00);
        chk("rst_chan", {busy, awvalid, wvalid, arvalid, bready, rready}, 6'b0);
        chk("tied", {awlen, awsize, awburst, arlen, arsize, arburst},
            {8'd0, 3'd4, 2'b01, 8'd0, 3'd4, 2'b01});

        run_pass("clean", 8'hC0, 1, 0);
        if (aw_log.size() == NW) begin
            chk("clean_addr1", aw_log[1], 64'h10);
            chk("clean_addr3", aw_log[3], 64'h30);
            chk("clean_data0", w_log[0], 128'hA5A50000_A5A50000_A5A50000_A5A50000);
            chk("clean_data3", w_log[3], 128'hA5A50003_A5A50003_A5A50003_A5A50003);
        end

        rcor = 4'b0100;
        run_pass("corrupt", 8'h81, 0, 0);
        rcor = '0;

        maxd = 12;
        for (int k = 0; k < 3; k++) run_pass("backpressure", 8'hC0, 0, 0);

        maxd = 3; bslv = 4'b0001; rslv = 4'b0010; rcor = 4'b0010;
        run_pass("errresp", 8'h82, 0, 0);
        bslv = '0; rslv = '0; rcor = '0;

        maxd = 4;
        run_pass("busy_start", 8'hC0, 0, 1);

        // watchdog: awready never comes
        model_en = 0; aw_stuck = 1; maxd = 0;
        @(posedge clk); #1 start = 1;
        n = 0;
        while (!awvalid && n < 20) begin @(negedge clk); #1; n++; end
        chk("to_rise", awvalid, 1'b1);
        start = 0;
        for (int j = 1; j <= TO; j++) begin
            @(negedge clk); #1;
            if (j == TO - 1) chk("to_early", out[7], 1'b0);
            if (j == TO) begin
                chk("to_out", out, 8'hA0);
                chk("to_chan", {busy, awvalid, wvalid, arvalid, bready, rready}, 6'b0);
            end
        end
        do_reset();
        aw_stuck = 0; model_en = 1;

        // asynchronous reset in the middle of the read phase
        maxd = 8;
        @(posedge clk); #1 start = 1;
        repeat (4) @(posedge clk);
        #1 start = 0;
        n = 0;
        while (!(rready && m_r >= 1) && n < 2000) begin @(negedge clk); #1; n++; end
        chk("rd_reach", rready, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("arst_out", out, 8'h00);
        chk("arst_chan", {busy, awvalid, wvalid, arvalid, bready, rready}, 6'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        maxd = 0;
        run_pass("after_rst", 8'hC0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        tests++; fails++;
        $display("FAIL global_watchdog: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
